// File: rtl/spi_slave_bus_sequencer_if.sv
// Single-word bus-master port between the SPI slave sequencer and the system bus.
interface spi_slave_bus_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [31:0]           bus_wdata;
    logic [3:0]            bus_be;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [31:0]           bus_rdata;
    logic                  bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/spi_slave_bus_sequencer.sv
// Turns SPI address/command words plus data streams into single-word bus transactions,
// with read prefetch into a small return buffer and clean drain on chip-select release.
module spi_slave_bus_sequencer #(
    parameter int unsigned RD_BUF_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_rd_wr,
    input  logic [15:0]           wrap_length,
    input  logic                  xfer_end,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [31:0]           wdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [31:0]           rdata,
    spi_slave_bus_sequencer_if.master bus,
    output logic                  txn_err,
    output logic                  busy
);
    localparam int unsigned PTR_W = $clog2(RD_BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [15:0]           idx;
    logic [15:0]           idx_inc;
    logic [15:0]           wrap_len;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      buf_count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [31:0]           buf_mem [RD_BUF_DEPTH];

    logic                  req;
    logic                  we;
    logic [31:0]           wdata_bus;
    logic                  cmd_take;
    logic                  gnt_take;
    logic                  rd_gnt;
    logic                  rsp_take;
    logic                  push;
    logic                  pop;

    // Next-state and combinational handshake outputs
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        cmd_take    = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        req         = 1'b0;
        we          = 1'b0;
        wdata_bus   = 32'd0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_take  = 1'b1;
                    state_nxt = cmd_rd_wr ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                req         = wdata_valid;
                we          = 1'b1;
                wdata_bus   = wdata;
                wdata_ready = bus.bus_gnt & wdata_valid;
                if (xfer_end) state_nxt = S_IDLE;
            end
            S_READ: begin
                // Throttle so every granted read is guaranteed a buffer slot
                req         = (SUM_W'(outstanding) + SUM_W'(buf_count)) < SUM_W'(RD_BUF_DEPTH);
                rdata_valid = buf_count != '0;
                if (xfer_end) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding == '0 || (outstanding == CNT_W'(1) && bus.bus_rvalid))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign gnt_take  = req & bus.bus_gnt;
    assign rd_gnt    = gnt_take & (state == S_READ);
    assign rsp_take  = bus.bus_rvalid & (outstanding != '0) & ((state == S_READ) | (state == S_DRAIN));
    assign push      = rsp_take & (state == S_READ);
    assign pop       = rdata_valid & rdata_ready;
    assign idx_inc   = (wrap_len != 16'd0 && idx == wrap_len - 16'd1) ? 16'd0 : idx + 16'd1;

    assign bus.bus_req   = req;
    assign bus.bus_we    = we;
    assign bus.bus_wdata = wdata_bus;
    assign bus.bus_be    = 4'hF;
    assign bus.bus_addr  = base + ADDR_WIDTH'({idx, 2'b00});
    assign rdata         = rdata_valid ? buf_mem[rd_ptr] : 32'd0;
    assign busy          = state != S_IDLE;

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state       <= S_IDLE;
            base        <= '0;
            idx         <= '0;
            wrap_len    <= '0;
            outstanding <= '0;
            buf_count   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            txn_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_take) begin
                base     <= cmd_addr & ~ADDR_WIDTH'(3);
                idx      <= '0;
                wrap_len <= wrap_length;
                txn_err  <= 1'b0;
            end
            if (gnt_take) idx <= idx_inc;
            unique case ({rd_gnt, rsp_take})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: ;
            endcase
            if (rsp_take && bus.bus_err) txn_err <= 1'b1;
            // Abandoned transfer: drop anything buffered, late responses are discarded
            if (state == S_DRAIN) begin
                buf_count <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                unique case ({push, pop})
                    2'b10:   buf_count <= buf_count + CNT_W'(1);
                    2'b01:   buf_count <= buf_count - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (push) buf_mem[wr_ptr] <= bus.bus_rdata;
    end

    a_no_overflow: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
        (push && !pop) |-> (buf_count != CNT_W'(RD_BUF_DEPTH)));

endmodule

// File: tb/tb_spi_slave_bus_sequencer.sv
// Randomised self-checking bench for spi_slave_bus_sequencer with a transaction-level bus model.
module tb_spi_slave_bus_sequencer;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_rd_wr, xfer_end;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   wrap_length;
    logic          wdata_valid, wdata_ready, rdata_valid, rdata_ready, txn_err, busy;
    logic [31:0]   wdata, rdata;

    always #5 clk = ~clk;

    spi_slave_bus_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    spi_slave_bus_sequencer #(.RD_BUF_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rd_wr(cmd_rd_wr), .wrap_length(wrap_length), .xfer_end(xfer_end),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .bus(bus), .txn_err(txn_err), .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;

    // Bus slave model configuration and logs
    int gnt_mode = 0;     // 0: grant every request, 1: random grants
    int gnt_budget = -1;  // grants left, -1 unlimited
    int lat = 1;
    int err_at = -1;      // response index that carries bus_err
    int rsp_cnt = 0;
    int cyc = 0;
    typedef struct { int due; logic [31:0] data; } rsp_t;
    rsp_t          rsp_q[$];
    logic [31:0]   gnt_addr_q[$];
    logic [31:0]   gnt_data_q[$];
    logic          gnt_we_q[$];
    logic [31:0]   pop_q[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + a[15:0]};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] b, input int unsigned wrap,
                                             input int unsigned k);
        int unsigned w;
        w = (wrap == 0) ? (k % 65536) : (k % wrap);
        return {b[31:2], 2'b00} + 32'(w * 4);
    endfunction

    initial begin : responder
        forever begin
            logic g;
            @(posedge clk);
            #2;
            cyc++;
            if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                bus.bus_rvalid = 1'b1;
                bus.bus_rdata  = rsp_q[0].data;
                bus.bus_err    = (rsp_cnt == err_at);
                rsp_q.delete(0);
                rsp_cnt++;
            end else begin
                bus.bus_rvalid = 1'b0;
                bus.bus_rdata  = 32'hDEAD_BEEF;
                bus.bus_err    = 1'b0;
            end
            g = bus.bus_req && (gnt_budget != 0) && ((gnt_mode == 0) || ($urandom_range(0, 1) == 1));
            bus.bus_gnt = g;
            if (g) begin
                gnt_addr_q.push_back(bus.bus_addr);
                gnt_data_q.push_back(bus.bus_wdata);
                gnt_we_q.push_back(bus.bus_we);
                if (gnt_budget > 0) gnt_budget--;
                if (!bus.bus_we) rsp_q.push_back('{due: cyc + lat, data: mem_data(bus.bus_addr)});
            end
        end
    end

    initial begin : pop_logger
        forever begin
            @(negedge clk);
            if (rdata_valid && rdata_ready) pop_q.push_back(rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gnt_addr_q.delete();
        gnt_data_q.delete();
        gnt_we_q.delete();
        pop_q.delete();
        rsp_cnt = 0;
    endtask

    task automatic bus_cfg(input int mode, input int l, input int budget);
        gnt_mode = mode;
        lat = l;
        gnt_budget = budget;
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic rd, input logic [15:0] wrap);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_rd_wr = rd;
        wrap_length = wrap;
        tick();
        cmd_valid = 1'b0;
        cmd_addr = $urandom;
        wrap_length = 16'($urandom);
    endtask

    task automatic end_xfer();
        xfer_end = 1'b1;
        tick();
        xfer_end = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
            else tick();
        end
        n_total++;
        if (done) n_pass++;
        else $display("FAIL %s idle_timeout busy=%b expected 0", name, busy);
        if (done) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready);
        else n_pass++;
        n_total++;
        if ({busy, bus.bus_req, rdata_valid, wdata_ready, txn_err, bus.bus_we} !== 6'b0)
            $display("FAIL reset_flags got %b expected 000000",
                     {busy, bus.bus_req, rdata_valid, wdata_ready, txn_err, bus.bus_we});
        else n_pass++;
        n_total++;
        if ({bus.bus_addr, bus.bus_wdata, rdata} !== 96'b0)
            $display("FAIL reset_data got %h %h %h expected zeros", bus.bus_addr, bus.bus_wdata, rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_write_burst();
        logic [31:0] w [3];
        for (int k = 0; k < 3; k++) w[k] = $urandom;
        bus_cfg(0, 1, -1);
        clear_logs();
        start_cmd(32'h1000_0002, 1'b0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            wdata_valid = 1'b1;
            wdata = w[k];
            @(negedge clk);
            n_total++;
            if (wdata_ready !== 1'b1 || bus.bus_addr !== exp_addr(32'h1000_0000, 0, k))
                $display("FAIL wr_burst_beat%0d got ready=%b addr=%h expected 1 %h", k, wdata_ready,
                         bus.bus_addr, exp_addr(32'h1000_0000, 0, k));
            else n_pass++;
            tick();
        end
        wdata_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if (bus.bus_req !== 1'b0 || wdata_ready !== 1'b0)
                $display("FAIL wr_burst_idle got req=%b ready=%b expected 0 0", bus.bus_req, wdata_ready);
            else n_pass++;
            tick();
        end
        n_total++;
        if (gnt_addr_q.size() != 3) $display("FAIL wr_burst_count got %0d expected 3", gnt_addr_q.size());
        else n_pass++;
        for (int k = 0; k < gnt_addr_q.size() && k < 3; k++) begin
            n_total++;
            if (gnt_addr_q[k] !== 32'h1000_0000 + 32'(4 * k) || gnt_data_q[k] !== w[k] || gnt_we_q[k] !== 1'b1)
                $display("FAIL wr_burst_txn%0d got %h/%h/%b expected %h/%h/1", k, gnt_addr_q[k],
                         gnt_data_q[k], gnt_we_q[k], 32'h1000_0000 + 32'(4 * k), w[k]);
            else n_pass++;
        end
        end_xfer();
        wait_idle("wr_burst");
    endtask

    task automatic test_write_random();
        for (int it = 0; it < 4; it++) begin
            logic [31:0] b;
            int unsigned wrap, n, k;
            logic [31:0] w [$];
            bit to;
            b = $urandom;
            wrap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            n = $urandom_range(3, 8);
            w.delete();
            for (int i = 0; i < int'(n); i++) w.push_back($urandom);
            bus_cfg(1, 1, -1);
            clear_logs();
            start_cmd(b, 1'b0, 16'(wrap));
            k = 0;
            to = 1;
            for (int c = 0; c < 200 && to; c++) begin
                wdata_valid = ($urandom_range(0, 3) != 0);
                wdata = w[k];
                @(negedge clk);
                if (wdata_ready) k++;
                tick();
                if (k == n) to = 0;
            end
            wdata_valid = 1'b0;
            n_total++;
            if (to || gnt_addr_q.size() != n)
                $display("FAIL wr_rand%0d_count got %0d expected %0d", it, gnt_addr_q.size(), n);
            else n_pass++;
            for (int i = 0; i < gnt_addr_q.size() && i < int'(n); i++) begin
                n_total++;
                if (gnt_addr_q[i] !== exp_addr(b, wrap, i) || gnt_data_q[i] !== w[i] || gnt_we_q[i] !== 1'b1)
                    $display("FAIL wr_rand%0d_txn%0d got %h/%h expected %h/%h", it, i, gnt_addr_q[i],
                             gnt_data_q[i], exp_addr(b, wrap, i), w[i]);
                else n_pass++;
            end
            end_xfer();
            wait_idle("wr_rand");
        end
    endtask

    task automatic test_read_throttle();
        logic [31:0] b = 32'h4000_0010;
        bus_cfg(0, 1, -1);
        clear_logs();
        rdata_ready = 1'b0;
        start_cmd(b, 1'b1, 16'd0);
        repeat (8) tick();
        @(negedge clk);
        n_total++;
        if (gnt_addr_q.size() != DEPTH || bus.bus_req !== 1'b0 || rdata_valid !== 1'b1)
            $display("FAIL rd_throttle_fill got grants=%0d req=%b valid=%b expected %0d 0 1",
                     gnt_addr_q.size(), bus.bus_req, rdata_valid, DEPTH);
        else n_pass++;
        tick();
        for (int p = 0; p < 4; p++) begin
            rdata_ready = 1'b1;
            @(negedge clk);
            n_total++;
            if (rdata !== mem_data(exp_addr(b, 0, p)))
                $display("FAIL rd_throttle_data%0d got %h expected %h", p, rdata, mem_data(exp_addr(b, 0, p)));
            else n_pass++;
            tick();
            rdata_ready = 1'b0;
            repeat (3) tick();
            @(negedge clk);
            n_total++;
            if (gnt_addr_q.size() != 5 + p || bus.bus_req !== 1'b0)
                $display("FAIL rd_throttle_refill%0d got grants=%0d req=%b expected %0d 0", p,
                         gnt_addr_q.size(), bus.bus_req, 5 + p);
            else n_pass++;
            tick();
        end
        end_xfer();
        wait_idle("rd_throttle");
    endtask

    task automatic test_wrap();
        bus_cfg(0, 1, 7);
        clear_logs();
        rdata_ready = 1'b1;
        start_cmd(32'h0000_0200, 1'b1, 16'd3);
        for (int c = 0; c < 40 && gnt_addr_q.size() < 7; c++) tick();
        repeat (4) tick();
        n_total++;
        if (gnt_addr_q.size() != 7 || pop_q.size() != 7)
            $display("FAIL wrap_count got grants=%0d pops=%0d expected 7 7", gnt_addr_q.size(), pop_q.size());
        else n_pass++;
        for (int i = 0; i < gnt_addr_q.size() && i < pop_q.size(); i++) begin
            n_total++;
            if (gnt_addr_q[i] !== exp_addr(32'h200, 3, i) || pop_q[i] !== mem_data(exp_addr(32'h200, 3, i)))
                $display("FAIL wrap_txn%0d got %h/%h expected %h/%h", i, gnt_addr_q[i], pop_q[i],
                         exp_addr(32'h200, 3, i), mem_data(exp_addr(32'h200, 3, i)));
            else n_pass++;
        end
        rdata_ready = 1'b0;
        end_xfer();
        wait_idle("wrap");
    endtask

    task automatic test_abort();
        bus_cfg(0, 5, 3);
        clear_logs();
        rdata_ready = 1'b0;
        start_cmd(32'h0000_8000, 1'b1, 16'd0);
        repeat (3) tick();
        xfer_end = 1'b1;
        @(negedge clk);
        n_total++;
        if (gnt_addr_q.size() != 3 || rsp_cnt != 0)
            $display("FAIL abort_outstanding got grants=%0d rsps=%0d expected 3 0", gnt_addr_q.size(), rsp_cnt);
        else n_pass++;
        tick();
        xfer_end = 1'b0;
        @(negedge clk);
        n_total++;
        if (rdata_valid !== 1'b0 || bus.bus_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL abort_drain got valid=%b req=%b busy=%b expected 0 0 1", rdata_valid, bus.bus_req, busy);
        else n_pass++;
        for (int c = 0; c < 30 && rsp_cnt < 3; c++) begin
            tick();
            @(negedge clk);
        end
        n_total++;
        if (rsp_cnt != 3 || busy !== 1'b1)
            $display("FAIL abort_last_rsp got rsps=%0d busy=%b expected 3 1", rsp_cnt, busy);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || pop_q.size() != 0)
            $display("FAIL abort_idle got busy=%b cmd_ready=%b pops=%0d expected 0 1 0", busy, cmd_ready, pop_q.size());
        else n_pass++;
        tick();
        bus_cfg(0, 1, 0);
        start_cmd(32'h0000_9000, 1'b1, 16'd0);
        repeat (2) tick();
        @(negedge clk);
        n_total++;
        if (rdata_valid !== 1'b0) $display("FAIL abort_next_empty got %b expected 0", rdata_valid);
        else n_pass++;
        tick();
        end_xfer();
        wait_idle("abort");
    endtask

    task automatic test_back_to_back_events();
        logic [31:0] w, b;
        // xfer_end together with a write grant
        w = $urandom;
        bus_cfg(0, 1, -1);
        clear_logs();
        start_cmd(32'h3000_0008, 1'b0, 16'd0);
        wdata_valid = 1'b1;
        wdata = w;
        xfer_end = 1'b1;
        @(negedge clk);
        n_total++;
        if (wdata_ready !== 1'b1) $display("FAIL end_gnt_ready got %b expected 1", wdata_ready);
        else n_pass++;
        tick();
        xfer_end = 1'b0;
        wdata_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || gnt_addr_q.size() != 1)
            $display("FAIL end_gnt_idle got busy=%b ready=%b grants=%0d expected 0 1 1", busy, cmd_ready,
                     gnt_addr_q.size());
        else n_pass++;
        n_total++;
        if (gnt_addr_q.size() == 1 && (gnt_addr_q[0] !== 32'h3000_0008 || gnt_data_q[0] !== w))
            $display("FAIL end_gnt_txn got %h/%h expected 30000008/%h", gnt_addr_q[0], gnt_data_q[0], w);
        else n_pass++;
        tick();
        // push and pop together with the buffer at capacity
        b = {$urandom_range(0, 65535), 16'h0};
        bus_cfg(0, 1, 6);
        clear_logs();
        rdata_ready = 1'b0;
        start_cmd(b, 1'b1, 16'd0);
        repeat (8) tick();
        rdata_ready = 1'b1;
        tick();
        rdata_ready = 1'b0;
        tick();
        rdata_ready = 1'b1;
        tick();
        rdata_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_total++;
        if (rdata_valid !== 1'b1 || bus.bus_req !== 1'b0 || pop_q.size() != 2)
            $display("FAIL full_pushpop got valid=%b req=%b pops=%0d expected 1 0 2", rdata_valid, bus.bus_req,
                     pop_q.size());
        else n_pass++;
        tick();
        rdata_ready = 1'b1;
        repeat (6) tick();
        rdata_ready = 1'b0;
        n_total++;
        if (pop_q.size() != 6) $display("FAIL full_order_count got %0d expected 6", pop_q.size());
        else n_pass++;
        for (int i = 0; i < pop_q.size(); i++) begin
            n_total++;
            if (pop_q[i] !== mem_data(exp_addr(b, 0, i)))
                $display("FAIL full_order%0d got %h expected %h", i, pop_q[i], mem_data(exp_addr(b, 0, i)));
            else n_pass++;
        end
        end_xfer();
        wait_idle("full");
    endtask

    task automatic test_error();
        bus_cfg(0, 1, 4);
        clear_logs();
        err_at = 1;
        rdata_ready = 1'b1;
        start_cmd(32'h0000_0A00, 1'b1, 16'd0);
        @(negedge clk);
        n_total++;
        if (txn_err !== 1'b0) $display("FAIL err_before got %b expected 0", txn_err);
        else n_pass++;
        tick();
        repeat (6) tick();
        @(negedge clk);
        n_total++;
        if (txn_err !== 1'b1 || pop_q.size() != 4)
            $display("FAIL err_set got err=%b pops=%0d expected 1 4", txn_err, pop_q.size());
        else n_pass++;
        n_total++;
        if (pop_q.size() > 1 && pop_q[1] !== mem_data(32'h0000_0A04))
            $display("FAIL err_data got %h expected %h", pop_q[1], mem_data(32'h0000_0A04));
        else n_pass++;
        tick();
        end_xfer();
        wait_idle("err");
        @(negedge clk);
        n_total++;
        if (txn_err !== 1'b1) $display("FAIL err_sticky got %b expected 1", txn_err);
        else n_pass++;
        tick();
        err_at = -1;
        bus_cfg(0, 1, 0);
        start_cmd(32'h0000_0B00, 1'b1, 16'd0);
        @(negedge clk);
        n_total++;
        if (txn_err !== 1'b0) $display("FAIL err_clear got %b expected 0", txn_err);
        else n_pass++;
        tick();
        rdata_ready = 1'b0;
        end_xfer();
        wait_idle("err_clear");
    endtask

    task automatic test_reset_mid_read();
        bus_cfg(0, 3, -1);
        clear_logs();
        rdata_ready = 1'b0;
        start_cmd(32'h0000_C000, 1'b1, 16'd0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b1 ||
            {busy, bus.bus_req, rdata_valid, wdata_ready, txn_err, bus.bus_we} !== 6'b0 ||
            bus.bus_addr !== 32'h0 || rdata !== 32'h0)
            $display("FAIL rst_mid got ready=%b flags=%b addr=%h rdata=%h expected 1 000000 0 0", cmd_ready,
                     {busy, bus.bus_req, rdata_valid, wdata_ready, txn_err, bus.bus_we}, bus.bus_addr, rdata);
        else n_pass++;
        tick();
        repeat (6) tick();
        bus_cfg(0, 1, 2);
        clear_logs();
        rdata_ready = 1'b1;
        start_cmd(32'h0000_D004, 1'b1, 16'd0);
        repeat (6) tick();
        n_total++;
        if (pop_q.size() != 2 || pop_q[0] !== mem_data(32'h0000_D004) || pop_q[1] !== mem_data(32'h0000_D008))
            $display("FAIL rst_recover got pops=%0d expected 2 matching words", pop_q.size());
        else n_pass++;
        rdata_ready = 1'b0;
        end_xfer();
        wait_idle("rst_recover");
    endtask

    task automatic test_read_random();
        for (int it = 0; it < 6; it++) begin
            logic [31:0] b;
            int unsigned wrap;
            b = $urandom;
            wrap = $urandom_range(0, 5);
            bus_cfg(1, $urandom_range(1, 4), -1);
            clear_logs();
            start_cmd(b, 1'b1, 16'(wrap));
            repeat ($urandom_range(10, 40)) begin
                rdata_ready = ($urandom_range(0, 1) == 1);
                tick();
            end
            rdata_ready = 1'b0;
            end_xfer();
            wait_idle("rd_rand");
            n_total++;
            if (rsp_q.size() != 0 || pop_q.size() > gnt_addr_q.size())
                $display("FAIL rd_rand%0d_drain got pending=%0d pops=%0d grants=%0d expected 0 <=grants", it,
                         rsp_q.size(), pop_q.size(), gnt_addr_q.size());
            else n_pass++;
            for (int i = 0; i < gnt_addr_q.size(); i++) begin
                n_total++;
                if (gnt_addr_q[i] !== exp_addr(b, wrap, i) || gnt_we_q[i] !== 1'b0)
                    $display("FAIL rd_rand%0d_addr%0d got %h we=%b expected %h 0", it, i, gnt_addr_q[i],
                             gnt_we_q[i], exp_addr(b, wrap, i));
                else n_pass++;
            end
            for (int i = 0; i < pop_q.size(); i++) begin
                n_total++;
                if (pop_q[i] !== mem_data(exp_addr(b, wrap, i)))
                    $display("FAIL rd_rand%0d_data%0d got %h expected %h", it, i, pop_q[i],
                             mem_data(exp_addr(b, wrap, i)));
                else n_pass++;
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_rd_wr = 1'b0;
        wrap_length = '0;
        xfer_end = 1'b0;
        wdata_valid = 1'b0;
        wdata = '0;
        rdata_ready = 1'b0;
        bus.bus_gnt = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata = '0;
        bus.bus_err = 1'b0;
        test_reset();
        test_write_burst();
        test_write_random();
        test_read_throttle();
        test_wrap();
        test_abort();
        test_back_to_back_events();
        test_error();
        test_reset_mid_read();
        test_read_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
